// File: rtl/four_bit_array_multiplier_if.sv
// Operand/product bundle for the 4x4 array multiplier.
// The master drives the operands and the slave returns the registered product.
interface four_bit_array_multiplier_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;

    modport master (
        output a,
        output b,
        input  p
    );

    modport slave (
        input  a,
        input  b,
        output p
    );
endinterface

// File: rtl/four_bit_array_multiplier.sv
// Unsigned 4x4 array multiplier: AND-gate partial products reduced by rows of adder cells,
// with the 8-bit product captured in a single register stage.
module four_bit_array_multiplier (
    input  logic                        clk,
    input  logic                        rst,
    four_bit_array_multiplier_if.slave  mul_if
);

    logic [3:0] pp [4];
    logic [7:0] p_d;
    logic [7:0] p_q;

    // Row acc holds the running sums, cy the ripple carry, y the shifted previous row.
    logic [3:0] acc;
    logic [3:0] y;
    logic       cy;
    logic       x;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pp_row
            for (gj = 0; gj < 4; gj++) begin : g_pp_col
                assign pp[gi][gj] = mul_if.a[gj] & mul_if.b[gi];
            end
        end
    endgenerate

    // Each row adds pp[i] to the previous row shifted right by one. The row's LSB sum
    // becomes p[i], and its carry-out becomes the MSB of the next row's input.
    // Row 1's LSB cell has no carry-in, so it behaves as a half adder.
    always_comb begin
        p_d    = '0;
        acc    = pp[0];
        y      = '0;
        cy     = 1'b0;
        x      = 1'b0;
        p_d[0] = pp[0][0];
        for (int i = 1; i < 4; i++) begin
            y  = {cy, acc[3:1]};
            cy = 1'b0;
            for (int j = 0; j < 4; j++) begin
                x      = pp[i][j];
                acc[j] = x ^ y[j] ^ cy;
                cy     = (x & y[j]) | (cy & (x ^ y[j]));
            end
            p_d[i] = acc[0];
        end
        p_d[7:4] = {cy, acc[3:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= 8'h00;
        end else begin
            p_q <= p_d;
        end
    end

    assign mul_if.p = p_q;

endmodule

// File: tb/tb_four_bit_array_multiplier.sv
// Directed and exhaustive checks of the registered 4x4 array multiplier.
module tb_four_bit_array_multiplier;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    four_bit_array_multiplier_if mul_if ();

    four_bit_array_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (mul_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: p=%02h expected %02h", tag, obs, exp);
        end else begin
            $display("check %s: p=%02h", tag, obs);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // {a, b, expected product}, all hand-computed
    logic [15:0] vec [8];
    initial begin
        vec[0] = {4'b1011, 4'b1010, 8'h6E};
        vec[1] = {4'b1111, 4'b1010, 8'h96};
        vec[2] = {4'b1001, 4'b1110, 8'h7E};
        vec[3] = {4'b1011, 4'b1111, 8'hA5};
        vec[4] = {4'd0,    4'd15,   8'h00};
        vec[5] = {4'd15,   4'd0,    8'h00};
        vec[6] = {4'd1,    4'd15,   8'h0F};
        vec[7] = {4'd15,   4'd15,   8'hE1};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: p=%02h expected completion", mul_if.p);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prev;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        mul_if.a = 4'h0;
        mul_if.b = 4'h0;

        // Asynchronous reset must clear p before any clock edge.
        #2;
        mul_if.a = 4'hB;
        mul_if.b = 4'hA;
        rst      = 1'b1;
        #1;
        check_value("reset_async", mul_if.p, 8'h00);
        next_edge();
        check_value("reset_hold1", mul_if.p, 8'h00);
        next_edge();
        check_value("reset_hold2", mul_if.p, 8'h00);
        rst = 1'b0;

        // Back-to-back directed vectors and corners, one new pair per cycle.
        prev = 8'h00;
        for (int k = 0; k < 8; k++) begin
            mul_if.a = vec[k][15:12];
            mul_if.b = vec[k][11:8];
            #1;
            check_value($sformatf("hold_%0d", k), mul_if.p, prev);
            @(posedge clk);
            #1;
            check_value($sformatf("vec_%0d_%0dx%0d", k, vec[k][15:12], vec[k][11:8]),
                        mul_if.p, vec[k][7:0]);
            prev = vec[k][7:0];
        end

        // Mid-stream reset while p holds 0xA5.
        mul_if.a = 4'b1011;
        mul_if.b = 4'b1111;
        next_edge();
        check_value("pre_reset", mul_if.p, 8'hA5);
        mul_if.a = 4'd3;
        mul_if.b = 4'd5;
        rst      = 1'b1;
        #1;
        check_value("mid_reset", mul_if.p, 8'h00);
        #1;
        rst = 1'b0;
        #1;
        check_value("post_release", mul_if.p, 8'h00);
        next_edge();
        check_value("after_reset_3x5", mul_if.p, 8'h0F);

        // Exhaustive sweep against a behavioural product.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                mul_if.a = 4'(ia);
                mul_if.b = 4'(ib);
                next_edge();
                check_value($sformatf("exh_%0dx%0d", ia, ib), mul_if.p, 8'(ia * ib));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
